vedic_nxn_pipe: RTL and testbench
=================================

VEDIC_NXN_PIPE -- requirements
Module: vedic_nxn_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal values are powers of two from 2 to 32.
REQ-002 SHALL have parameter SIGNED, default 0: 0 means unsigned operands, 1 means two's-complement operands and result.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_a_tdata, input, WIDTH bits: operand A.
REQ-006 SHALL have port s_a_tvalid, input, 1 bit: operand A valid.
REQ-007 SHALL have port s_a_tready, output, 1 bit: operand A accepted.
REQ-008 SHALL have port s_b_tdata, input, WIDTH bits: operand B.
REQ-009 SHALL have port s_b_tvalid, input, 1 bit: operand B valid.
REQ-010 SHALL have port s_b_tready, output, 1 bit: operand B accepted.
REQ-011 SHALL have port m_result_tdata, output, 2*WIDTH bits: product A*B.
REQ-012 SHALL have port m_tvalid, output, 1 bit: result valid.
REQ-013 SHALL have port m_tready, input, 1 bit: downstream ready.
REQ-014 SHALL have port busy, output, 1 bit: high while any pipeline stage holds a valid entry.

Function
REQ-015 SHALL compute the product by recursive Vedic (Urdhva-Tiryagbhyam) decomposition: an N x N multiply is split into four N/2 x N/2 sub-products down to 2x2 leaf cells, then the partial products are summed.
REQ-016 SHALL have latency L = log2(WIDTH)+1 cycles from accept to m_tvalid when there is no stall: one input register stage, then one register per recursion level (WIDTH=2 gives L=2; WIDTH=8 gives L=4).
REQ-017 SHALL join the two inputs: a transfer occurs only on a cycle where s_a_tvalid, s_b_tvalid and the pipeline enable ce are all 1.
REQ-018 SHALL define ce = ~m_tvalid | m_tready.
REQ-019 SHALL drive s_a_tready = s_b_tready = s_a_tvalid & s_b_tvalid & ce; neither side is consumed alone.
REQ-020 SHALL advance all stages together when ce=1 and freeze every stage's data and valid when ce=0 (global stall; bubbles are not collapsed).
REQ-021 SHALL hold m_result_tdata and m_tvalid stable while m_tvalid=1 and m_tready=0.
REQ-022 SHALL sustain one result per cycle when both inputs are continuously valid and m_tready=1.
REQ-023 SHALL, when SIGNED=0, produce m_result_tdata equal to the exact unsigned product (no overflow is possible in 2*WIDTH bits).
REQ-024 SHALL, when SIGNED=1, produce the exact two's-complement product:
  - multiply the operand magnitudes unsigned;
  - negate the result when sign(A) XOR sign(B) is 1;
  - carry the sign bit through the pipeline alongside the data;
  - the -2^(WIDTH-1) * -2^(WIDTH-1) case SHALL be exact.
REQ-025 SHALL keep entries in strict FIFO order; results are never dropped or duplicated.
REQ-026 SHALL drive busy = OR of all stage valid bits, including the output stage.
REQ-027 SHALL ignore data on cycles where a transfer does not occur.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear every stage valid bit: m_tvalid=0, busy=0, s_a_tready=0, s_b_tready=0 (ready is gated by valid).
REQ-029 SHALL drive m_result_tdata to 0 on reset.
REQ-030 SHALL, on reset mid-operation, discard all in-flight products; none appears after rst is deasserted.
REQ-031 SHALL accept a new transfer on the first edge after rst returns to 0.

Verification
REQ-032 Unsigned full scale (WIDTH=8, SIGNED=0): A=0xFF, B=0xFF, m_tready=1 -> 0xFE01 with m_tvalid exactly 4 cycles after accept; A=0x02, B=0x03 -> 0x0006.
REQ-033 Signed corners (WIDTH=8, SIGNED=1):
  - A=0x80, B=0x80 -> 0x4000;
  - A=0xFF, B=0x01 -> 0xFFFF;
  - A=0x7F, B=0x80 -> 0xC080.
REQ-034 Streaming: 16 back-to-back random pairs with both valids held high and m_tready=1 -> 16 consecutive results, one per cycle, in order, each matching a reference model.
REQ-035 Backpressure: m_tready=0 for 5 cycles while m_tvalid=1 ->
  - output data held constant;
  - s_a_tready=s_b_tready=0;
  - no loss or reordering once m_tready returns to 1.
REQ-036 One-sided valid: s_a_tvalid=1, s_b_tvalid=0 for 10 cycles -> s_a_tready stays 0, no result produced; raising s_b_tvalid then yields exactly one product.
REQ-037 Mid-flight reset: rst pulsed for 1 cycle with 3 entries in flight -> m_tvalid=0 and busy=0 after that edge; no stale result ever emerges; the next pair is accepted and correct.
REQ-038 Width sweep: repeat REQ-032 and REQ-034 for WIDTH=2 (3*3=9, L=2), WIDTH=4 and WIDTH=16, with SIGNED=0 and SIGNED=1.

Source files
------------

// File: rtl/vedic_nxn_pipe.sv
// Pipelined N x N Vedic (Urdhva-Tiryagbhyam) multiplier.
// Operands are reduced to unsigned magnitudes in the input stage. The first
// level multiplies every pair of 2-bit digits with a 2x2 leaf cell. Each later
// level merges four sub-products into a product of twice the operand width.
// In signed mode, the last level applies the sign before its register.
//
// Handshake: the two inputs are joined. A pair transfers only on a rising edge
// where s_a_tvalid and s_b_tvalid are both high and the pipeline enable
// ce = ~m_tvalid | m_tready is high. Both readies show exactly that condition,
// so neither side is ever consumed alone. The output presents m_tvalid with
// m_result_tdata and holds both until m_tready is seen. When ce is low, every
// stage freezes in place.
module vedic_nxn_pipe #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     s_a_tdata,
  input  logic                 s_a_tvalid,
  output logic                 s_a_tready,
  input  logic [WIDTH-1:0]     s_b_tdata,
  input  logic                 s_b_tvalid,
  output logic                 s_b_tready,
  output logic [2*WIDTH-1:0]   m_result_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 busy
);
  localparam int LVLS = $clog2(WIDTH);

  logic             w_ce;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg;
  logic [WIDTH-1:0] r_a_mag;
  logic [WIDTH-1:0] r_b_mag;
  // Bit 0 is the input stage; bit k+1 is recursion level k (the last one drives m_tvalid).
  logic [LVLS:0]    r_v_sr;
  // Bit k is the sign that belongs with the data entering recursion level k.
  logic [LVLS-1:0]  r_neg_sr;

  assign w_ce       = ~m_tvalid | m_tready;
  // Ready is also held low during reset, so nothing is taken on a reset edge.
  assign w_xfer     = s_a_tvalid & s_b_tvalid & w_ce & ~rst;
  assign s_a_tready = w_xfer;
  assign s_b_tready = w_xfer;
  assign m_tvalid   = r_v_sr[LVLS];
  assign busy       = |r_v_sr;

  // 2x2 leaf cell: vertical and crosswise partial products with explicit carries.
  function automatic logic [3:0] leaf2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] mid;
    logic [1:0] top;
    mid = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    top = {1'b0, x[1] & y[1]} + {1'b0, mid[1]};
    return {top, mid[0], x[0] & y[0]};
  endfunction

  // Reduce the operands to magnitudes. -2^(WIDTH-1) maps onto itself, and that value is already its exact unsigned magnitude.
  always_comb begin
    w_a_mag = s_a_tdata;
    w_b_mag = s_b_tdata;
    w_neg   = 1'b0;
    if (SIGNED != 0) begin
      if (s_a_tdata[WIDTH-1]) w_a_mag = -s_a_tdata;
      if (s_b_tdata[WIDTH-1]) w_b_mag = -s_b_tdata;
      w_neg = s_a_tdata[WIDTH-1] ^ s_b_tdata[WIDTH-1];
    end
  end

  // Input stage registers plus the valid and sign shift chains, which advance together on ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_v_sr   <= '0;
      r_neg_sr <= '0;
    end else if (w_ce) begin
      if (w_xfer) begin
        r_a_mag <= w_a_mag;
        r_b_mag <= w_b_mag;
      end
      r_v_sr[0]   <= w_xfer;
      r_neg_sr[0] <= w_neg & w_xfer;
      for (int k = 1; k <= LVLS; k++) r_v_sr[k] <= r_v_sr[k-1];
      for (int k = 1; k < LVLS; k++) r_neg_sr[k] <= r_neg_sr[k-1];
    end
  end

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    localparam int SW = 2 << k;        // sub-operand width produced at this level
    localparam int H  = SW / 2;        // sub-operand width of the level below
    localparam int NB = WIDTH / SW;    // sub-operand blocks per operand
    logic [2*SW-1:0] w_p [NB*NB];
    logic [2*SW-1:0] w_d [NB*NB];
    logic [2*SW-1:0] r_p [NB*NB];

    if (k == 0) begin : g_leaf
      // Leaf level: one 2x2 product for every pair of A digit and B digit.
      always_comb begin
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < NB; j++)
            w_p[i*NB+j] = leaf2(r_a_mag[2*i +: 2], r_b_mag[2*j +: 2]);
      end
    end else begin : g_join
      // Merge four half-width products: hh<<SW + (hl+lh)<<H + ll.
      always_comb begin
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < NB; j++)
            w_p[i*NB+j] =
                ({{SW{1'b0}}, g_lvl[k-1].r_p[(2*i+1)*2*NB + 2*j+1]} << SW)
              + ({{SW{1'b0}}, g_lvl[k-1].r_p[(2*i+1)*2*NB + 2*j]}   << H)
              + ({{SW{1'b0}}, g_lvl[k-1].r_p[(2*i)*2*NB + 2*j+1]}   << H)
              +  {{SW{1'b0}}, g_lvl[k-1].r_p[(2*i)*2*NB + 2*j]};
      end
    end

    // The last level sees one full product and applies the carried sign.
    always_comb begin
      for (int n = 0; n < NB*NB; n++) w_d[n] = w_p[n];
      if ((k == LVLS-1) && r_neg_sr[k]) w_d[0] = -w_p[0];
    end

    // Level register, frozen with the rest of the pipeline when ce is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int n = 0; n < NB*NB; n++) r_p[n] <= '0;
      end else if (w_ce) begin
        for (int n = 0; n < NB*NB; n++) r_p[n] <= w_d[n];
      end
    end
  end

  assign m_result_tdata = g_lvl[LVLS-1].r_p[0];

endmodule

// File: tb/tb_vedic_nxn_pipe.sv
// Bench for vedic_nxn_pipe. It builds eight configurations: WIDTH 2, 4, 8 and
// 16, each with SIGNED 0 and 1. Each configuration has its own driver, its own
// scoreboard queue and its own monitor. Expected products come from plain
// integer arithmetic.
module tb_vedic_nxn_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  wire [7:0] w_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  for (genvar c = 0; c < 8; c++) begin : g_cfg
    localparam int W = 2 << (c / 2);
    localparam int S = c % 2;
    localparam int L = $clog2(W) + 1;

    logic           rst, av, bv, a_rdy, b_rdy, m_v, m_rdy, busy, done;
    logic [W-1:0]   a, b, ones, mn, mx, ra, rb;
    logic [2*W-1:0] m_d;
    logic [2*W-1:0] exp_q[$];
    int             n_out = 0;

    assign w_done[c] = done;

    vedic_nxn_pipe #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .s_a_tdata      (a),
      .s_a_tvalid     (av),
      .s_a_tready     (a_rdy),
      .s_b_tdata      (b),
      .s_b_tvalid     (bv),
      .s_b_tready     (b_rdy),
      .m_result_tdata (m_d),
      .m_tvalid       (m_v),
      .m_tready       (m_rdy),
      .busy           (busy)
    );

    // Reference: interpret operands as integers, multiply, keep 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      longint xv, yv, p;
      xv = longint'(x);
      yv = longint'(y);
      if (S == 1 && x[W-1]) xv = xv - (longint'(1) << W);
      if (S == 1 && y[W-1]) yv = yv - (longint'(1) << W);
      p = xv * yv;
      return p[2*W-1:0];
    endfunction

    task automatic c_chk(input string nm, input logic [63:0] act, input logic [63:0] e);
      chk($sformatf("W%0d S%0d %s", W, S, nm), act, e);
    endtask

    task automatic drain();
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        if (exp_q.size() == 0) break;
      end
      c_chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Single transfer into an empty pipeline, with a latency check; rel_rst releases reset on the same cycle.
    task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y, input bit rel_rst);
      int lat;
      @(posedge clk); #1;
      if (rel_rst) rst = 1'b0;
      a = x; b = y; av = 1'b1; bv = 1'b1; m_rdy = 1'b1;
      @(negedge clk);
      if (rel_rst) begin
        c_chk("post_reset_valid_busy", 64'({m_v, busy}), 64'd0);
        c_chk("post_reset_data", 64'(m_d), 64'd0);
      end
      c_chk("accept_ready", 64'({a_rdy, b_rdy}), 64'd3);
      if (a_rdy) exp_q.push_back(ref_mul(x, y));
      @(posedge clk); #1;
      av = 1'b0; bv = 1'b0; a = W'($urandom); b = W'($urandom);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (m_v) begin
          lat = n;
          break;
        end
      end
      c_chk("latency", 64'(lat), 64'(L));
      drain();
    endtask

    // Monitor: every output handshake pops the oldest expected product.
    always @(negedge clk) begin
      if (rst === 1'b0 && m_v === 1'b1 && m_rdy === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL W%0d S%0d unexpected_result: got 0x%0h expected no output", W, S, m_d);
        end else begin
          c_chk("result", 64'(m_d), 64'(exp_q.pop_front()));
        end
      end
    end

    initial begin
      int cyc, acc, n0;
      done = 1'b0;
      rst = 1'b1; av = 1'b0; bv = 1'b0; a = '0; b = '0; m_rdy = 1'b1;
      ones = '1; mn = '0; mn[W-1] = 1'b1; mx = ~mn;
      repeat (3) @(posedge clk);
      @(negedge clk);
      c_chk("reset_flags", 64'({m_v, busy, a_rdy, b_rdy}), 64'd0);
      c_chk("reset_data", 64'(m_d), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed corners: full scale, small values, most-negative squared, -1*1, max*min, zero.
      send_one(ones, ones, 1'b0);
      send_one(W'(2), W'(3), 1'b0);
      send_one(mn, mn, 1'b0);
      send_one(ones, W'(1), 1'b0);
      send_one(mx, mn, 1'b0);
      send_one('0, W'($urandom), 1'b0);
      send_one(W'($urandom), W'($urandom), 1'b0);

      // Streaming: both valids held high, one new random pair per cycle.
      n0 = n_out; cyc = 0; acc = 0;
      @(posedge clk); #1;
      while (acc < 16 && cyc < 100) begin
        a = W'($urandom); b = W'($urandom); av = 1'b1; bv = 1'b1;
        @(negedge clk);
        cyc++;
        if (a_rdy) begin
          exp_q.push_back(ref_mul(a, b));
          acc++;
        end
        @(posedge clk); #1;
      end
      av = 1'b0; bv = 1'b0;
      c_chk("stream_cycles", 64'(cyc), 64'd16);
      repeat (L) @(negedge clk);
      @(posedge clk); #1;
      c_chk("stream_outputs", 64'(n_out - n0), 64'd16);
      drain();

      // Backpressure: fill with m_tready low, then hold for five cycles.
      @(posedge clk); #1;
      m_rdy = 1'b0; av = 1'b1; bv = 1'b1;
      for (int n = 0; n < 40; n++) begin
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        if (a_rdy) exp_q.push_back(ref_mul(a, b));
        if (m_v) break;
        @(posedge clk); #1;
      end
      c_chk("bp_fill_valid", 64'(m_v), 64'd1);
      c_chk("bp_depth", 64'(exp_q.size()), 64'(L));
      for (int n = 0; n < 5; n++) begin
        @(posedge clk); #1;
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        c_chk("stall_valid", 64'(m_v), 64'd1);
        c_chk("stall_ready", 64'({a_rdy, b_rdy}), 64'd0);
        c_chk("stall_data", 64'(m_d), 64'((exp_q.size() != 0) ? exp_q[0] : {2*W{1'b1}}));
      end
      @(posedge clk); #1;
      av = 1'b0; bv = 1'b0; m_rdy = 1'b1;
      drain();

      // One-sided valid: A alone must never be taken.
      n0 = n_out;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        av = 1'b1; bv = 1'b0; a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        c_chk("one_sided_ready_valid", 64'({a_rdy, b_rdy, m_v}), 64'd0);
      end
      ra = W'($urandom); rb = W'($urandom);
      send_one(ra, rb, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      c_chk("one_sided_count", 64'(n_out - n0), 64'd1);

      // Mid-flight reset: park several entries behind a stalled output, then pulse reset.
      @(posedge clk); #1;
      m_rdy = 1'b0;
      for (int n = 0; n < 3; n++) begin
        a = W'($urandom); b = W'($urandom); av = 1'b1; bv = 1'b1;
        @(negedge clk);
        if (a_rdy) exp_q.push_back(ref_mul(a, b));
        @(posedge clk); #1;
      end
      av = 1'b0; bv = 1'b0;
      @(negedge clk);
      c_chk("busy_before_reset", 64'(busy), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete();
      ra = W'($urandom); rb = W'($urandom);
      send_one(ra, rb, 1'b1);
      n0 = n_out;
      repeat (10) @(posedge clk);
      #1;
      c_chk("no_stale_after_reset", 64'(n_out - n0), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 60000; k++) begin
      @(posedge clk);
      if (&w_done) break;
    end
    if (!(&w_done)) begin
      n_checks++;
      n_errs++;
      $display("FAIL timeout: done=0x%0h expected 0xff", w_done);
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
